// File: rtl/me_result_serializer.sv
// me_result_serializer: FIFO-buffered result words sent as framed bursts (start, beats, stop) over LANES pins.
// Define ME_SER_PARITY_EN to insert a per-lane even-parity cycle before the stop cycle.
module me_result_serializer #(
  parameter int RESULT_W   = 20,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                res_valid,
  input  logic [RESULT_W-1:0] res_data,
  output logic                res_ready,
  output logic [LANES-1:0]    ser_out,
  output logic                ser_busy
);
  localparam int NBEATS = (RESULT_W + LANES - 1) / LANES;
  localparam int SW     = NBEATS * LANES;
  localparam int AW     = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int BW     = NBEATS > 1 ? $clog2(NBEATS) : 1;
`ifdef ME_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [LANES-1:0] par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [RESULT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] shreg;
  logic [BW-1:0] beat;
  logic [LANES-1:0] out_n;
  logic push, pop, last;
  assign res_ready = count != CW'(FIFO_DEPTH);
  assign push = res_valid && res_ready && !init;
  assign pop  = (state == IDLE || state == STOP) && count != '0;
  assign last = beat == BW'(NBEATS - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   state_n = count != '0 ? START : IDLE;
      START:  state_n = DATA;
`ifdef ME_SER_PARITY_EN
      DATA:   state_n = last ? PARITY : DATA;
      PARITY: state_n = STOP;
`else
      DATA:   state_n = last ? STOP : DATA;
`endif
      STOP:   state_n = count != '0 ? START : IDLE;
      default: state_n = IDLE;
    endcase
`ifdef ME_SER_PARITY_EN
    out_n = state == START ? '1 : state == DATA ? shreg[SW-1 -: LANES] : state == PARITY ? par : '0;
`else
    out_n = state == START ? '1 : state == DATA ? shreg[SW-1 -: LANES] : '0;
`endif
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= res_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shreg    <= '0;
      beat     <= '0;
      ser_out  <= '0;
      ser_busy <= 1'b0;
`ifdef ME_SER_PARITY_EN
      par      <= '0;
`endif
    end else if (init) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ser_out  <= '0;
      ser_busy <= 1'b0;
    end else begin
      state    <= state_n;
      ser_out  <= out_n;
      ser_busy <= state != IDLE;
      count    <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        shreg  <= SW'(mem[rd_ptr]) << (SW - RESULT_W);
`ifdef ME_SER_PARITY_EN
        par    <= '0;
`endif
      end
      if (state == START) beat <= '0;
      if (state == DATA) begin
        shreg <= shreg << LANES;
        beat  <= beat + 1'b1;
`ifdef ME_SER_PARITY_EN
        par   <= par ^ shreg[SW-1 -: LANES];
`endif
      end
    end
  end
endmodule
